// File: rtl/fmsg_pkg.sv
// Shared definitions for the fmsg receive path: default field widths,
// field offsets, the broadcast address helper and the packed word layout.
package fmsg_pkg;

    localparam int DEF_TYPE_W    = 2;
    localparam int DEF_DEST_W    = 2;
    localparam int DEF_PAYLOAD_W = 4;

    localparam int PAYLOAD_LSB = 0;
    localparam int DEST_LSB    = DEF_PAYLOAD_W;
    localparam int TYPE_LSB    = DEF_PAYLOAD_W + DEF_DEST_W;

    // "type" is a keyword, so the TYPE field is called msg_type here.
    typedef struct packed {
        logic [DEF_TYPE_W-1:0]    msg_type;
        logic [DEF_DEST_W-1:0]    dest;
        logic [DEF_PAYLOAD_W-1:0] payload;
    } fmsg_t;

    function automatic logic [31:0] bcast_addr(input int dest_w);
        return (32'd1 << dest_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fmsg_fifo.sv
// Small synchronous first-word-fall-through FIFO with an occupancy output.
// The head reads as zero while the FIFO is empty.
module fmsg_fifo
    import fmsg_pkg::*;
#(
    parameter int WIDTH = DEF_TYPE_W + DEF_DEST_W + DEF_PAYLOAD_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap on their own; level tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fmsg_rx_decoder.sv
// Address-filtering fmsg receiver: splits words into TYPE/DEST/PAYLOAD, queues
// words for this node (or broadcast) and counts the ones it throws away.
module fmsg_rx_decoder
    import fmsg_pkg::*;
#(
    parameter int TYPE_W    = DEF_TYPE_W,
    parameter int DEST_W    = DEF_DEST_W,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int DEPTH     = 4,
    parameter bit BCAST_EN  = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DEST_W-1:0]               my_dest,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [TYPE_W+DEST_W+PAYLOAD_W-1:0] in_fmsg,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [TYPE_W-1:0]               out_type,
    output logic [DEST_W-1:0]               out_dest,
    output logic [PAYLOAD_W-1:0]            out_payload,
    output logic [CNT_W-1:0]                filt_cnt,
    output logic [$clog2(DEPTH):0]          fifo_level
);

    localparam int WORD_W = TYPE_W + DEST_W + PAYLOAD_W;
    localparam logic [DEST_W-1:0] BCAST = DEST_W'(bcast_addr(DEST_W));

    logic [DEST_W-1:0] in_dest;
    logic              addr_hit;
    logic              in_xfer;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] head;

    assign in_dest  = in_fmsg[PAYLOAD_W +: DEST_W];
    assign addr_hit = (in_dest == my_dest) || (BCAST_EN && (in_dest == BCAST));
    assign in_xfer  = in_valid && in_ready;
    assign push     = in_xfer && addr_hit;
    assign drop     = in_xfer && !addr_hit;

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;

    fmsg_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (in_fmsg),
        .full    (fifo_full),
        .rd_en   (out_ready),
        .rd_data (head),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_type    = head[PAYLOAD_W + DEST_W +: TYPE_W];
    assign out_dest    = head[PAYLOAD_W +: DEST_W];
    assign out_payload = head[0 +: PAYLOAD_W];

    // Rejected words still complete their handshake; the counter sticks at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
        end else if (drop && (filt_cnt != '1)) begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fmsg_rx_decoder.sv
// Directed bench for fmsg_rx_decoder: a default instance and a second one with
// broadcast disabled and a 2-bit filter counter share the same stimulus.
module tb_fmsg_rx_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] my_dest;
    logic       in_valid;
    logic [7:0] in_fmsg;
    logic       out_ready;

    logic       a_in_ready, a_out_valid;
    logic [1:0] a_out_type, a_out_dest;
    logic [3:0] a_out_payload;
    logic [7:0] a_filt_cnt;
    logic [2:0] a_fifo_level;

    logic       b_in_ready, b_out_valid;
    logic [1:0] b_out_type, b_out_dest;
    logic [3:0] b_out_payload;
    logic [1:0] b_filt_cnt;
    logic [2:0] b_fifo_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fmsg_rx_decoder dut (
        .clk(clk), .rst(rst), .my_dest(my_dest),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_fmsg(in_fmsg),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_type(a_out_type), .out_dest(a_out_dest), .out_payload(a_out_payload),
        .filt_cnt(a_filt_cnt), .fifo_level(a_fifo_level)
    );

    fmsg_rx_decoder #(.BCAST_EN(1'b0), .CNT_W(2)) dut_nb (
        .clk(clk), .rst(rst), .my_dest(my_dest),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_fmsg(in_fmsg),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_type(b_out_type), .out_dest(b_out_dest), .out_payload(b_out_payload),
        .filt_cnt(b_filt_cnt), .fifo_level(b_fifo_level)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offers one word and returns #1 after the edge on which it was taken.
    task automatic applyStimulus(input logic [7:0] word);
        int waited = 0;
        in_valid = 1'b1;
        in_fmsg  = word;
        while (!a_in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) checkOutput("stim_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        my_dest   = 2'b00;
        in_valid  = 1'b0;
        in_fmsg   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", a_out_valid, 0);
        checkOutput("rst_level", a_fifo_level, 0);
        checkOutput("rst_filt", a_filt_cnt, 0);
        checkOutput("rst_payload", a_out_payload, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", a_in_ready, 1);

        // Unicast match, first-word fall-through after one edge
        my_dest = 2'b10;
        applyStimulus(8'b01101111);
        checkOutput("t1_out_valid", a_out_valid, 1);
        checkOutput("t1_type", a_out_type, 2'b01);
        checkOutput("t1_dest", a_out_dest, 2'b10);
        checkOutput("t1_payload", a_out_payload, 4'hF);
        checkOutput("t1_filt", a_filt_cnt, 0);
        checkOutput("t1_nb_payload", b_out_payload, 4'hF);
        popOne();
        checkOutput("t1_empty_valid", a_out_valid, 0);
        checkOutput("t1_empty_type", a_out_type, 0);

        // One match, one drop
        my_dest = 2'b00;
        applyStimulus(8'b11000001);
        applyStimulus(8'b00011010);
        checkOutput("t2_type", a_out_type, 2'b11);
        checkOutput("t2_payload", a_out_payload, 4'h1);
        checkOutput("t2_filt", a_filt_cnt, 1);
        checkOutput("t2_level", a_fifo_level, 1);
        checkOutput("t2_nb_filt", b_filt_cnt, 1);
        popOne();
        checkOutput("t2_popped_level", a_fifo_level, 0);

        // Broadcast accepted only where enabled
        doReset();
        my_dest = 2'b01;
        applyStimulus(8'b00111010);
        checkOutput("t3_bc_valid", a_out_valid, 1);
        checkOutput("t3_bc_dest", a_out_dest, 2'b11);
        checkOutput("t3_bc_payload", a_out_payload, 4'hA);
        checkOutput("t3_bc_filt", a_filt_cnt, 0);
        checkOutput("t3_nb_valid", b_out_valid, 0);
        checkOutput("t3_nb_level", b_fifo_level, 0);
        checkOutput("t3_nb_filt", b_filt_cnt, 1);

        // Fill to full, hold the fifth word, then pop while full
        doReset();
        my_dest = 2'b10;
        for (int p = 1; p <= 4; p++) applyStimulus({2'b00, 2'b10, 4'(p)});
        checkOutput("t4_full_level", a_fifo_level, 4);
        checkOutput("t4_full_ready", a_in_ready, 0);
        in_valid = 1'b1;
        in_fmsg  = {2'b00, 2'b10, 4'd5};
        @(posedge clk); #1;
        checkOutput("t4_held_level", a_fifo_level, 4);
        checkOutput("t4_held_head", a_out_payload, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("t5_pop_only_level", a_fifo_level, 3);
        checkOutput("t5_ready_back", a_in_ready, 1);
        checkOutput("t5_head", a_out_payload, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("t5_push_after", a_fifo_level, 4);
        checkOutput("t5_nb_level", b_fifo_level, 4);
        out_ready = 1'b1;
        for (int p = 2; p <= 5; p++) begin
            checkOutput($sformatf("t4_order_valid%0d", p), a_out_valid, 1);
            checkOutput($sformatf("t4_order_payload%0d", p), a_out_payload, p);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checkOutput("t4_drained_level", a_fifo_level, 0);
        checkOutput("t4_drained_valid", a_out_valid, 0);

        // Counter saturation and reset with words queued and one pending
        doReset();
        my_dest = 2'b00;
        for (int p = 0; p < 5; p++) applyStimulus({2'b10, 2'b01, 4'(p)});
        checkOutput("t6_filt_wide", a_filt_cnt, 5);
        checkOutput("t6_filt_sat", b_filt_cnt, 3);
        applyStimulus({2'b01, 2'b00, 4'h7});
        applyStimulus({2'b01, 2'b00, 4'h8});
        checkOutput("t6_queued", a_fifo_level, 2);
        in_valid = 1'b1;
        in_fmsg  = {2'b01, 2'b00, 4'h9};
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", a_out_valid, 0);
        checkOutput("t6_async_level", a_fifo_level, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("t6_rst_valid", a_out_valid, 0);
        checkOutput("t6_rst_level", a_fifo_level, 0);
        checkOutput("t6_rst_filt", a_filt_cnt, 0);
        checkOutput("t6_rst_nb_filt", b_filt_cnt, 0);
        @(posedge clk); #1;
        checkOutput("t6_no_emit", a_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmsg_rx_decoder.md
Name: fmsg_rx_decoder

Overview:
- Parametrised, buffered successor to the combinational fmsg field decoder.
- Accepts fmsg words on a valid/ready stream and splits each into TYPE, DEST and PAYLOAD fields with configurable widths.
- Drops words not addressed to this node (unicast match or broadcast) and queues accepted words in a small FIFO.
- Sits between the link receiver and the iCE40 command dispatcher; also exports a saturating filtered-message counter for telemetry.

Parameters:
- TYPE_W, 2, TYPE field width (MSBs of the word).
- DEST_W, 2, DEST field width (below TYPE).
- PAYLOAD_W, 4, PAYLOAD field width (LSBs).
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- BCAST_EN, 1, when 1, DEST of all ones is accepted by every node.
- CNT_W, 8, width of the filtered-message counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- my_dest  in  DEST_W  this node's address; sampled on every accept cycle.
- in_valid  in  1  input word present.
- in_ready  out  1  decoder can take a word (FIFO not full).
- in_fmsg  in  TYPE_W+DEST_W+PAYLOAD_W  word laid out as {TYPE, DEST, PAYLOAD}.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_type  out  TYPE_W  head TYPE field.
- out_dest  out  DEST_W  head DEST field.
- out_payload  out  PAYLOAD_W  head PAYLOAD field.
- filt_cnt  out  CNT_W  count of handshaken words dropped by the address filter; saturates.
- fifo_level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, immediate): FIFO emptied, read and write pointers 0, fifo_level=0, out_valid=0, filt_cnt=0. out_type, out_dest and out_payload read 0 while empty. in_ready=1 once rst deasserts.
- Handshake:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
  - in_valid may be held with in_ready low; the word stays pending and no state changes.
- in_ready = (fifo_level != DEPTH), combinational from registered state only. There is no combinational path from out_ready to in_ready.
- Address filter on a transferred word, with D = in_fmsg[PAYLOAD_W +: DEST_W]:
  - Accept if D == my_dest, or if BCAST_EN=1 and D == all ones.
  - An accepted word is pushed to the FIFO.
  - A rejected word is consumed (handshake completes) and not stored; filt_cnt increments by 1 and stops at 2^CNT_W-1.
- Latency: a word accepted at edge N gives out_valid=1 with its fields just after edge N (first-word fall-through). Minimum 1 cycle, no bypass path.
- Ordering is strictly FIFO; fields are never modified.
- Simultaneous push and pop:
  - When not full, level is unchanged and both pointers advance.
  - When full, in_ready=0, so no push occurs even if a pop happens in the same cycle; in_ready rises the cycle after the pop.
- Empty: out_valid=0; out_ready is ignored.
- Pointers wrap modulo DEPTH; the level counter distinguishes full from empty.
- Reset mid-transfer: all pending and queued words are discarded; nothing is emitted after reset until a new accept.
- in_fmsg and my_dest are don't-care when in_valid=0 or in_ready=0.

Decomposition:
- Package fmsg_pkg:
  - Default field widths.
  - Field offset constants: PAYLOAD_LSB=0, DEST_LSB=PAYLOAD_W, TYPE_LSB=PAYLOAD_W+DEST_W.
  - Broadcast-address function: all ones of DEST_W.
  - Packed struct fmsg_t {type, dest, payload}.
- One sub-module, fmsg_fifo: parametrised sync FIFO (WIDTH, DEPTH), FWFT, with level output. The decoder instantiates it with WIDTH = TYPE_W+DEST_W+PAYLOAD_W.

Test Plan:
- Default parameters, my_dest=2'b10; send 8'b01101111 -> out_valid rises 1 cycle later; out_type=01, out_dest=10, out_payload=1111; filt_cnt=0.
- my_dest=2'b00; send 8'b11000001 then 8'b00011010 -> first delivered (type 11, payload 0001); second dropped; filt_cnt=1; fifo_level=1.
- BCAST_EN=1, my_dest=2'b01; send 8'b00111010 -> accepted with dest 11. Repeat with BCAST_EN=0 -> dropped, filt_cnt=1.
- out_ready=0; push 5 matching words (payloads 1..5) with DEPTH=4 -> in_ready=0 after the 4th, 5th held; raise out_ready -> payloads 1,2,3,4,5 in order; level returns to 0.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> pop only; level 4→3; in_ready=1 next cycle; push occurs after that.
- CNT_W=2; send 5 non-matching words, then assert rst for 1 cycle mid-stream with 2 queued -> filt_cnt saturates at 3; after reset out_valid=0, fifo_level=0, filt_cnt=0.
